// File: rtl/sp_ram_bus_arb_if.sv
// One master port of the RAM front-end: request/grant plus a later response beat.
// Handshake: a request transfers in the cycle where req && gnt; the master holds req and
// its command until gnt; exactly one rvalid pulse returns per transfer, in grant order.
interface sp_ram_bus_arb_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int NB_COL     = 4,
    parameter int COL_WIDTH  = 8
);
    localparam int DW = NB_COL * COL_WIDTH;

    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [NB_COL-1:0]     be;
    logic [DW-1:0]         wdata;
    logic                  rvalid;
    logic [DW-1:0]         rdata;
    logic                  err;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/sp_ram_bus_arb.sv
// Two-master round-robin front-end for a single-port byte-write RAM: word addressing,
// out-of-range filtering and a fixed-latency response pipeline routed back by master id.
module sp_ram_bus_arb #(
    parameter int NB_COL     = 4,
    parameter int COL_WIDTH  = 8,
    parameter int RAM_DEPTH  = 16384,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    localparam int DW = NB_COL * COL_WIDTH,
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clka,
    input  logic                 rsta,
    sp_ram_bus_arb_if.slave      m0,
    sp_ram_bus_arb_if.slave      m1,
    output logic [AW-1:0]        ram_addra,
    output logic [DW-1:0]        ram_dina,
    output logic [NB_COL-1:0]    ram_wea,
    output logic                 ram_ena,
    output logic                 ram_regcea,
    output logic                 ram_rsta,
    input  logic [DW-1:0]        ram_douta,
    output logic                 prio
);
    typedef enum logic {PRIO_M0 = 1'b0, PRIO_M1 = 1'b1} prio_t;

    localparam logic [ADDR_WIDTH-2:0] DEPTH_W = (ADDR_WIDTH-1)'(RAM_DEPTH);

    prio_t                 prio_q;
    logic                  gnt0, gnt1, any_gnt, sel;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic                  we_sel;
    logic [NB_COL-1:0]     be_sel;
    logic [DW-1:0]         wdata_sel;
    logic [ADDR_WIDTH-3:0] widx;
    logic                  oob;
    logic                  unused_addr_bits;

    logic [RD_LATENCY-1:0] pipe_vld, pipe_id, pipe_oob;
    logic                  out_vld, out_id, out_oob;

    // Contested cycles go to the pointer; otherwise the lone requester wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rsta) begin
            if (m0.req && m1.req) begin
                gnt0 = (prio_q == PRIO_M0);
                gnt1 = (prio_q == PRIO_M1);
            end else begin
                gnt0 = m0.req;
                gnt1 = m1.req;
            end
        end
    end

    assign m0.gnt  = gnt0;
    assign m1.gnt  = gnt1;
    assign any_gnt = gnt0 || gnt1;
    assign sel     = gnt1;

    assign addr_sel  = sel ? m1.addr  : m0.addr;
    assign we_sel    = sel ? m1.we    : m0.we;
    assign be_sel    = sel ? m1.be    : m0.be;
    assign wdata_sel = sel ? m1.wdata : m0.wdata;

    assign widx             = addr_sel[ADDR_WIDTH-1:2];
    assign unused_addr_bits = ^addr_sel[1:0];
    assign oob              = ({1'b0, widx} >= DEPTH_W);

    // Out-of-range grants still occupy a pipeline slot but never touch the RAM.
    assign ram_ena    = any_gnt && !oob;
    assign ram_wea    = (ram_ena && we_sel) ? be_sel : '0;
    assign ram_dina   = wdata_sel;
    assign ram_addra  = widx[AW-1:0];
    assign ram_rsta   = rsta;
    assign ram_regcea = (RD_LATENCY == 2) ? pipe_vld[0] : 1'b0;

    always_ff @(posedge clka) begin
        if (rsta) begin
            prio_q   <= PRIO_M0;
            pipe_vld <= '0;
            pipe_id  <= '0;
            pipe_oob <= '0;
        end else begin
            if (m0.req && m1.req) begin
                prio_q <= (prio_q == PRIO_M0) ? PRIO_M1 : PRIO_M0;
            end
            pipe_vld[0] <= any_gnt;
            pipe_id[0]  <= sel;
            pipe_oob[0] <= oob;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
                pipe_oob[i] <= pipe_oob[i-1];
            end
        end
    end

    assign prio = prio_q;

    // Responses are suppressed while reset is asserted so in-flight beats never surface.
    assign out_vld = pipe_vld[RD_LATENCY-1] && !rsta;
    assign out_id  = pipe_id[RD_LATENCY-1];
    assign out_oob = pipe_oob[RD_LATENCY-1];

    assign m0.rvalid = out_vld && !out_id;
    assign m1.rvalid = out_vld && out_id;
    assign m0.err    = m0.rvalid && out_oob;
    assign m1.err    = m1.rvalid && out_oob;
    assign m0.rdata  = (m0.rvalid && !out_oob) ? ram_douta : '0;
    assign m1.rdata  = (m1.rvalid && !out_oob) ? ram_douta : '0;
endmodule

// File: tb/tb_sp_ram_bus_arb.sv
// Bench for sp_ram_bus_arb: one instance per read latency, both fed the same vector table,
// each backed by a behavioural write-first byte-write RAM.
module tb_sp_ram_bus_arb;
    localparam int AWB = 18;
    localparam int W   = 50;   // {due[15:0], id, err, data[31:0]}

    typedef struct {
        logic        r0;
        logic [17:0] a0;
        logic        we0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic        r1;
        logic [17:0] a1;
        logic        we1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic        g0;
        logic        g1;
        logic [31:0] xd;
        logic        xe;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic prev_g = 1'b0;

    logic [W-1:0] exp_qa[$];
    logic [W-1:0] exp_qb[$];
    vec_t         vecs[$];

    sp_ram_bus_arb_if #(.ADDR_WIDTH(AWB), .NB_COL(4), .COL_WIDTH(8)) ma0 ();
    sp_ram_bus_arb_if #(.ADDR_WIDTH(AWB), .NB_COL(4), .COL_WIDTH(8)) ma1 ();
    sp_ram_bus_arb_if #(.ADDR_WIDTH(AWB), .NB_COL(4), .COL_WIDTH(8)) mb0 ();
    sp_ram_bus_arb_if #(.ADDR_WIDTH(AWB), .NB_COL(4), .COL_WIDTH(8)) mb1 ();

    logic [13:0] a_addr, b_addr;
    logic [31:0] a_din, b_din, a_dout, b_dout, b_s1;
    logic [3:0]  a_wea, b_wea;
    logic        a_ena, b_ena, a_regce, b_regce, a_rrst, b_rrst, a_prio, b_prio;
    logic [31:0] mem_a [0:16383];
    logic [31:0] mem_b [0:16383];

    sp_ram_bus_arb #(.ADDR_WIDTH(AWB), .RD_LATENCY(1)) dut_a (
        .clka(clk), .rsta(rst), .m0(ma0), .m1(ma1),
        .ram_addra(a_addr), .ram_dina(a_din), .ram_wea(a_wea), .ram_ena(a_ena),
        .ram_regcea(a_regce), .ram_rsta(a_rrst), .ram_douta(a_dout), .prio(a_prio)
    );

    sp_ram_bus_arb #(.ADDR_WIDTH(AWB), .RD_LATENCY(2)) dut_b (
        .clka(clk), .rsta(rst), .m0(mb0), .m1(mb1),
        .ram_addra(b_addr), .ram_dina(b_din), .ram_wea(b_wea), .ram_ena(b_ena),
        .ram_regcea(b_regce), .ram_rsta(b_rrst), .ram_douta(b_dout), .prio(b_prio)
    );

    // clock / reset-independent bookkeeping
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] be);
        merge = old;
        for (int i = 0; i < 4; i++) if (be[i]) merge[8*i +: 8] = din[8*i +: 8];
    endfunction

    always @(posedge clk) begin
        if (a_ena) begin
            mem_a[a_addr] <= merge(mem_a[a_addr], a_din, a_wea);
            a_dout        <= merge(mem_a[a_addr], a_din, a_wea);
        end
    end

    always @(posedge clk) begin
        if (b_ena) begin
            mem_b[b_addr] <= merge(mem_b[b_addr], b_din, b_wea);
            b_s1          <= merge(mem_b[b_addr], b_din, b_wea);
        end
        if (b_rrst) b_dout <= '0;
        else if (b_regce) b_dout <= b_s1;
    end

    function automatic vec_t mk(input logic r0, input logic [17:0] a0, input logic we0,
                                input logic [3:0] be0, input logic [31:0] d0,
                                input logic r1, input logic [17:0] a1, input logic we1,
                                input logic [3:0] be1, input logic [31:0] d1,
                                input logic g0, input logic g1, input logic [31:0] xd,
                                input logic xe);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.we0 = we0; v.be0 = be0; v.d0 = d0;
        v.r1 = r1; v.a1 = a1; v.we1 = we1; v.be1 = be1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.xd = xd; v.xe = xe;
        return v;
    endfunction

    // driver tasks
    task automatic drive(input vec_t v);
        ma0.req = v.r0; ma0.addr = v.a0; ma0.we = v.we0; ma0.be = v.be0; ma0.wdata = v.d0;
        mb0.req = v.r0; mb0.addr = v.a0; mb0.we = v.we0; mb0.be = v.be0; mb0.wdata = v.d0;
        ma1.req = v.r1; ma1.addr = v.a1; ma1.we = v.we1; ma1.be = v.be1; ma1.wdata = v.d1;
        mb1.req = v.r1; mb1.addr = v.a1; mb1.we = v.we1; mb1.be = v.be1; mb1.wdata = v.d1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: pop the head when its due cycle arrives, otherwise expect silence
    task automatic chk_resp(input int sel, input string tag, input logic rv0, input logic rv1,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic e0, input logic e1);
        logic [W-1:0] head;
        logic         due_now;
        head = '0;
        due_now = 1'b0;
        if (sel == 0) begin
            if (exp_qa.size() > 0 && exp_qa[0][49:34] == cyc[15:0]) begin
                head = exp_qa.pop_front();
                due_now = 1'b1;
            end
        end else begin
            if (exp_qb.size() > 0 && exp_qb[0][49:34] == cyc[15:0]) begin
                head = exp_qb.pop_front();
                due_now = 1'b1;
            end
        end
        if (due_now) begin
            check({tag, " rvalid0"}, rv0, !head[33]);
            check({tag, " rvalid1"}, rv1, head[33]);
            check({tag, " rdata"}, head[33] ? rd1 : rd0, head[31:0]);
            check({tag, " err"}, head[33] ? e1 : e0, head[32]);
        end else begin
            check({tag, " idle rvalid0"}, rv0, 1'b0);
            check({tag, " idle rvalid1"}, rv1, 1'b0);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic  g;
        string p;
        p = $sformatf("v%0d", idx);
        drive(v);
        @(negedge clk);
        g = v.g0 | v.g1;
        check({p, " a gnt0"}, ma0.gnt, v.g0);
        check({p, " a gnt1"}, ma1.gnt, v.g1);
        check({p, " b gnt0"}, mb0.gnt, v.g0);
        check({p, " b gnt1"}, mb1.gnt, v.g1);
        check({p, " a ena"}, a_ena, g & ~v.xe);
        check({p, " b ena"}, b_ena, g & ~v.xe);
        check({p, " a regcea"}, a_regce, 1'b0);
        check({p, " b regcea"}, b_regce, prev_g);
        chk_resp(0, {p, " a"}, ma0.rvalid, ma1.rvalid, ma0.rdata, ma1.rdata, ma0.err, ma1.err);
        chk_resp(1, {p, " b"}, mb0.rvalid, mb1.rvalid, mb0.rdata, mb1.rdata, mb0.err, mb1.err);
        if (g) begin
            exp_qa.push_back({16'(cyc + 1), v.g1, v.xe, v.xd});
            exp_qb.push_back({16'(cyc + 2), v.g1, v.xe, v.xd});
        end
        prev_g = g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle, v;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //          r0 a0        we be    d0            r1 a1        we be    d1            g0 g1 xd            xe
        vecs.push_back(mk(1, 'h00010, 1, 4'hF, 32'hDEADBEEF, 0, 0,        0, 0,    0,            1, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 'h00010, 0, 4'hF, 0,            0, 0,        0, 0,    0,            1, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 'h00020, 1, 4'hF, 32'h11223344, 0, 0,        0, 0,    0,            1, 0, 32'h11223344, 0));
        vecs.push_back(mk(1, 'h00020, 1, 4'h5, 32'hAABBCCDD, 0, 0,        0, 0,    0,            1, 0, 32'h11BB33DD, 0));
        vecs.push_back(mk(0, 0,       0, 0,    0,            1, 'h00020,  0, 4'hF, 0,            0, 1, 32'h11BB33DD, 0));
        vecs.push_back(mk(1, 'h00020, 1, 4'h0, 32'hFFFFFFFF, 0, 0,        0, 0,    0,            1, 0, 32'h11BB33DD, 0));
        vecs.push_back(mk(0, 0,       0, 0,    0,            1, 'h10000,  0, 4'hF, 0,            0, 1, 32'h0,        1));
        vecs.push_back(idle);
        vecs.push_back(mk(1, 'h00010, 0, 4'hF, 0,            1, 'h00020,  0, 4'hF, 0,            1, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 'h00020, 0, 4'hF, 0,            1, 'h00020,  0, 4'hF, 0,            0, 1, 32'h11BB33DD, 0));
        vecs.push_back(mk(1, 'h00020, 0, 4'hF, 0,            1, 'h00010,  0, 4'hF, 0,            1, 0, 32'h11BB33DD, 0));
        vecs.push_back(mk(1, 'h00010, 0, 4'hF, 0,            1, 'h00010,  0, 4'hF, 0,            0, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 0,       0, 0,    0,            1, 'h00030,  1, 4'hF, 32'h0BADF00D, 0, 1, 32'h0BADF00D, 0));
        vecs.push_back(mk(1, 'h00030, 0, 4'hF, 0,            0, 0,        0, 0,    0,            1, 0, 32'h0BADF00D, 0));
        vecs.push_back(mk(1, 'h0FFFC, 1, 4'hF, 32'h5A5A5A5A, 0, 0,        0, 0,    0,            1, 0, 32'h5A5A5A5A, 0));
        vecs.push_back(mk(0, 0,       0, 0,    0,            1, 'h0FFFC,  0, 4'hF, 0,            0, 1, 32'h5A5A5A5A, 0));
        vecs.push_back(mk(1, 'h3FFFC, 0, 4'hF, 0,            0, 0,        0, 0,    0,            1, 0, 32'h0,        1));
        vecs.push_back(mk(1, 'h00000, 1, 4'hF, 32'h01020304, 0, 0,        0, 0,    0,            1, 0, 32'h01020304, 0));
        vecs.push_back(mk(0, 0,       0, 0,    0,            1, 'h10000,  1, 4'hF, 32'hCAFEF00D, 0, 1, 32'h0,        1));
        vecs.push_back(mk(1, 'h00000, 0, 4'hF, 0,            0, 0,        0, 0,    0,            1, 0, 32'h01020304, 0));
        vecs.push_back(mk(1, 'h00012, 0, 4'hF, 0,            0, 0,        0, 0,    0,            1, 0, 32'hDEADBEEF, 0));
        vecs.push_back(idle);
        vecs.push_back(idle);
        vecs.push_back(idle);

        // reset: a pending request must not be granted
        rst = 1'b1;
        drive(mk(1, 'h00010, 0, 4'hF, 0, 1, 'h00020, 0, 4'hF, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("rst a gnt0", ma0.gnt, 1'b0);
        check("rst b gnt1", mb1.gnt, 1'b0);
        check("rst a ena", a_ena, 1'b0);
        check("rst b ena", b_ena, 1'b0);
        check("rst a rvalid0", ma0.rvalid, 1'b0);
        check("rst a ram_rsta", a_rrst, 1'b1);
        check("rst b ram_rsta", b_rrst, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(idle);
        @(negedge clk);
        check("post-rst a prio", a_prio, 1'b0);
        check("post-rst b prio", b_prio, 1'b0);
        check("post-rst b rvalid1", mb1.rvalid, 1'b0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(vecs[i], i);

        // contested grant, then reset the cycle after: the response must vanish
        v = mk(1, 'h00010, 0, 4'hF, 0, 1, 'h00020, 0, 4'hF, 0, 1, 0, 0, 0);
        drive(v);
        @(negedge clk);
        check("mf a gnt0", ma0.gnt, 1'b1);
        check("mf b gnt0", mb0.gnt, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(idle);
        @(negedge clk);
        check("mf a prio moved", a_prio, 1'b1);
        check("mf rst a rvalid0", ma0.rvalid, 1'b0);
        check("mf rst a rvalid1", ma1.rvalid, 1'b0);
        check("mf rst b rvalid0", mb0.rvalid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mf b rvalid0", mb0.rvalid, 1'b0);
        check("mf b rvalid1", mb1.rvalid, 1'b0);
        check("mf a rvalid0", ma0.rvalid, 1'b0);
        check("mf a prio", a_prio, 1'b0);
        check("mf b prio", b_prio, 1'b0);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        check("mf2 a gnt0", ma0.gnt, 1'b1);
        check("mf2 a gnt1", ma1.gnt, 1'b0);
        check("mf2 b gnt0", mb0.gnt, 1'b1);
        @(posedge clk);
        #1;
        drive(idle);
        @(negedge clk);
        check("mf2 a rvalid0", ma0.rvalid, 1'b1);
        check("mf2 a rdata", ma0.rdata, 32'hDEADBEEF);
        check("mf2 b early rvalid0", mb0.rvalid, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mf2 b rvalid0", mb0.rvalid, 1'b1);
        check("mf2 b rdata", mb0.rdata, 32'hDEADBEEF);
        check("mf2 a rvalid0 done", ma0.rvalid, 1'b0);

        check("a leftover", exp_qa.size(), 0);
        check("b leftover", exp_qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
